// File: rtl/dmem_access.sv
// Data-memory access stage: runs RV32I loads and stores for the MEM-stage
// instruction over a req/ready handshake. It stalls the pipeline while the
// access is outstanding and returns the aligned, extended load result on DDT.
module dmem_access #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] DDT,
    output logic        stall,
    output logic        done,
    output logic        fault
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    // The counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [6:0]    opcode;
    logic [2:0]    func;
    logic          is_load, is_store, op_hit, legal, aligned, go, bad;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt;
    logic [2:0]    func_q;
    logic [1:0]    off_q;
    logic          load_q;
    logic [CW-1:0] cnt;
    logic          tmo;
    logic [31:0]   word, ddt_nxt;
    logic          unused;

    assign opcode = inst[6:0];
    assign func   = inst[14:12];
    assign unused = ^{inst[31:15], inst[11:7]};

    // Decode the offered op: legality, alignment and the byte-lane pattern.
    always_comb begin
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        op_hit    = start && (is_load || is_store) && (state == IDLE);
        legal     = 1'b0;
        aligned   = 1'b1;
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        if (is_load) begin
            case (func)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (func)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end
        case (func[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        // Loads always fetch the whole word; only stores narrow the enables.
        if (is_store) begin
            case (func[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << addr[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_nxt    = 4'b0011 << {addr[1], 1'b0};
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = store_data;
                end
            endcase
        end
        go  = op_hit && legal && aligned;
        bad = op_hit && !(legal && aligned);
    end

    // Hold the pipeline from acceptance until the done cycle.
    assign stall = go || (state == BUSY);

    // Timeout fires on the last permitted BUSY cycle without ready.
    assign tmo = (TIMEOUT != 0) && (state == BUSY) && !dmem_ready
                 && (int'(cnt) == TIMEOUT - 1);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = BUSY;
            BUSY:    if (dmem_ready || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Count consecutive BUSY cycles; cleared whenever BUSY is left or not yet entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        cnt <= '0;
        else if (state == BUSY && state_nxt == BUSY)    cnt <= cnt + 1'b1;
        else                                            cnt <= '0;
    end

    // Align the returned word to the latched byte offset and extend per func.
    always_comb begin
        word = dmem_rdata >> {off_q, 3'b000};
        case (func_q)
            3'b000:  ddt_nxt = {{24{word[7]}}, word[7:0]};
            3'b100:  ddt_nxt = {24'd0, word[7:0]};
            3'b001:  ddt_nxt = {{16{word[15]}}, word[15:0]};
            3'b101:  ddt_nxt = {16'd0, word[15:0]};
            default: ddt_nxt = word;
        endcase
    end

    // Handshake outputs, latched op context, load result and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            DDT        <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            func_q     <= '0;
            off_q      <= '0;
            load_q     <= 1'b0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            if (state == IDLE) begin
                if (go) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= is_store;
                    dmem_addr  <= {addr[31:2], 2'b00};
                    dmem_be    <= be_nxt;
                    dmem_wdata <= wdata_nxt;
                    func_q     <= func;
                    off_q      <= addr[1:0];
                    load_q     <= is_load;
                end else if (bad) begin
                    done  <= 1'b1;
                    fault <= 1'b1;
                end
            end else begin
                if (dmem_ready) begin
                    dmem_req <= 1'b0;
                    done     <= 1'b1;
                    if (load_q) DDT <= ddt_nxt;
                end else if (tmo) begin
                    dmem_req <= 1'b0;
                    done     <= 1'b1;
                    fault    <= 1'b1;
                end
            end
        end
    end

endmodule
